// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / duty meter pair.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        MEAS
    } state_t;

    // Slot divider shared with the generator: slot length is DVSR+1 clocks.
    localparam logic [31:0] DVSR_DEFAULT  = 32'd10417;
    localparam int          WIDTH_DEFAULT = 8;

    // Largest period count before a frame is declared lost: 2^(width+1)-1.
    function automatic int tmo_limit(input int width);
        return (1 << (width + 1)) - 1;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus one history flop for edge detect.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst_i,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time and period of an external PWM input in prescaler slots
// and publishes the recovered duty word once per frame (or on a no-edge timeout).
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int          WIDTH = WIDTH_DEFAULT,
    parameter logic [31:0] DVSR  = DVSR_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             ena,
    input  logic             pwm_i,
    output logic [WIDTH-1:0] duty_o,
    output logic [WIDTH:0]   period_o,
    output logic             valid_o,
    output logic             timeout_o
);

    localparam logic [WIDTH:0] TMO_LIM = (WIDTH + 1)'(tmo_limit(WIDTH));
    localparam logic [WIDTH:0] ONE     = (WIDTH + 1)'(1);
    localparam logic [WIDTH:0] ZERO    = '0;

    logic level, rise;

    pwm_sync_edge u_sync (
        .clk   (clk),
        .rst_i (rst_i),
        .din   (pwm_i),
        .level (level),
        .rise  (rise),
        .fall  ()
    );

    // Slot timer, re-phased on every rising edge so ticks land mid-slot.
    logic [31:0] q;
    logic        tick;

    always_ff @(posedge clk) begin
        if (rst_i || rise)  q <= '0;
        else if (q == DVSR) q <= '0;
        else                q <= q + 32'd1;
    end

    assign tick = (q == (DVSR >> 1));

    state_t         state, state_nxt;
    logic [WIDTH:0] per_cnt, hi_cnt, per_nxt, hi_nxt, per_inc, hi_inc;
    logic           pub, pub_tmo;

    // Counts including the current tick; a tick coinciding with a rise belongs to the closing frame.
    always_comb begin
        per_inc = per_cnt;
        hi_inc  = hi_cnt;
        if (tick) begin
            if (per_cnt != TMO_LIM)           per_inc = per_cnt + ONE;
            if (level && (hi_cnt != TMO_LIM)) hi_inc  = hi_cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state   <= IDLE;
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            per_cnt <= per_nxt;
            hi_cnt  <= hi_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        per_nxt   = per_cnt;
        hi_nxt    = hi_cnt;
        pub       = 1'b0;
        pub_tmo   = 1'b0;
        if (!ena) begin
            state_nxt = IDLE;
            per_nxt   = ZERO;
            hi_nxt    = ZERO;
        end else begin
            case (state)
                IDLE: begin
                    per_nxt   = ZERO;
                    hi_nxt    = ZERO;
                    state_nxt = SYNC;
                end
                SYNC: begin
                    hi_nxt = ZERO;
                    if (rise) begin
                        per_nxt   = ZERO;
                        state_nxt = MEAS;
                    end else if (per_inc == TMO_LIM) begin
                        pub     = 1'b1;
                        pub_tmo = 1'b1;
                        per_nxt = ZERO;
                    end else begin
                        per_nxt = per_inc;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        pub     = 1'b1;
                        per_nxt = ZERO;
                        hi_nxt  = ZERO;
                    end else if (per_inc == TMO_LIM) begin
                        pub       = 1'b1;
                        pub_tmo   = 1'b1;
                        per_nxt   = ZERO;
                        hi_nxt    = ZERO;
                        state_nxt = SYNC;
                    end else begin
                        per_nxt = per_inc;
                        hi_nxt  = hi_inc;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            duty_o    <= '0;
            period_o  <= '0;
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            valid_o <= pub;
            if (pub) begin
                timeout_o <= pub_tmo;
                if (pub_tmo) begin
                    duty_o   <= {WIDTH{level}};
                    period_o <= '1;
                end else begin
                    duty_o   <= hi_inc[WIDTH] ? '1 : hi_inc[WIDTH-1:0];
                    period_o <= per_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops on valid_o.
module tb_pwm_duty_meter;

    localparam int          WIDTH = 8;
    localparam logic [31:0] DVSR  = 32'd3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b0;
    logic             pwm = 1'b0;
    logic [WIDTH-1:0] duty;
    logic [WIDTH:0]   period;
    logic             valid;
    logic             timeout;

    typedef struct {
        int duty;
        int per;
        int tmo;
    } exp_t;

    exp_t exp_q[$];
    exp_t pending;
    bit   pending_vld = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    pwm_duty_meter #(.WIDTH(WIDTH), .DVSR(DVSR)) dut (
        .clk       (clk),
        .rst_i     (rst),
        .ena       (ena),
        .pwm_i     (pwm),
        .duty_o    (duty),
        .period_o  (period),
        .valid_o   (valid),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got duty=%0d period=%0d timeout=%0d, want no valid at %0t",
                         duty, period, timeout, $time);
            end else begin
                e = exp_q.pop_front();
                check("duty",    int'(duty),    e.duty);
                check("period",  int'(period),  e.per);
                check("timeout", int'(timeout), e.tmo);
            end
        end
    end

    task automatic drive(input int hi, input int per);
        for (int i = 0; i < per; i++) begin
            pwm = (i < hi);
            @(negedge clk);
        end
    endtask

    task automatic push(input int d, input int p, input int t);
        exp_t e;
        e.duty = d;
        e.per  = p;
        e.tmo  = t;
        exp_q.push_back(e);
    endtask

    // The rise that opens a frame closes the previous one, so its result is queued here.
    task automatic frame(input int hi, input int per, input int ed, input int ep);
        if (pending_vld) push(pending.duty, pending.per, pending.tmo);
        pending.duty = ed;
        pending.per  = ep;
        pending.tmo  = 0;
        pending_vld  = 1'b1;
        drive(hi, per);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_duty",    int'(duty),    0);
        check("rst_period",  int'(period),  0);
        check("rst_valid",   int'(valid),   0);
        check("rst_timeout", int'(timeout), 0);
        rst = 1'b0;
        @(negedge clk);

        // Constant low after enable: timeouts every 511 ticks.
        push(0, 511, 1);
        push(0, 511, 1);
        ena = 1'b1;
        repeat (4300) @(negedge clk);

        // Duty 64 of 256 slots.
        repeat (4) frame(256, 1024, 64, 256);
        // Sweep.
        frame(4,    1024, 1,   256);
        frame(512,  1024, 128, 256);
        frame(1020, 1024, 255, 256);
        // Short period generator: 128 slots, 100 high.
        repeat (2) frame(400, 512, 100, 128);
        frame(256, 1024, 64, 256);

        // Reset pulse halfway through a duty-64 frame.
        if (pending_vld) push(pending.duty, pending.per, pending.tmo);
        pending_vld = 1'b0;
        drive(256, 512);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_duty",    int'(duty),    0);
        check("mid_rst_period",  int'(period),  0);
        check("mid_rst_valid",   int'(valid),   0);
        check("mid_rst_timeout", int'(timeout), 0);
        drive(0, 511);
        repeat (3) frame(256, 1024, 64, 256);

        // Input sticks high mid-measurement: MEAS timeout, then SYNC timeout.
        if (pending_vld) push(pending.duty, pending.per, pending.tmo);
        pending_vld = 1'b0;
        push(255, 511, 1);
        push(255, 511, 1);
        pwm = 1'b1;
        repeat (4300) @(negedge clk);
        ena = 1'b0;
        repeat (20) @(negedge clk);

        check("results_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
